row_fetch: RTL and testbench
============================

Name: row_fetch

Overview:
- Stage directly upstream of the video generator's row buffer.
- On each row request (GetRow plus StartBuffer level), the block burst-reads one display row of 8-bit palette indices from SDRAM through the memory controller's read port.
- It writes the row into the generator's 16-bit row-buffer write port (BufferAddr/BufferData/BufferWrite), one word per accepted memory beat.

Parameters:
- WORDS_PER_ROW, 512: 16-bit words fetched per row; must be a multiple of BURST_LEN and ≤512.
- BURST_LEN, 8: words per memory read burst; power of two.
- ROW_BASE, 0: word address of row 0 in SDRAM.
- ADDR_W, 22: SDRAM word-address width.

Ports:
- PixelClk2  in  1  sole clock; also the row-buffer write clock.
- Reset  in  1  asynchronous, active-high reset.
- GetRow  in  11  row number to fetch; sampled when a request is detected.
- StartBuffer  in  1  request level from the video generator (PixelClk domain); stays high until it sees BufferWrite.
- BufferAddr  out  9  row-buffer word address.
- BufferData  out  16  row-buffer write data.
- BufferWrite  out  1  row-buffer write strobe, one cycle per word.
- MemReq  out  1  burst read request to the SDRAM controller.
- MemAddr  out  ADDR_W  burst start word address.
- MemAck  in  1  controller accepted the request (one-cycle pulse).
- MemDataValid  in  1  MemData holds a valid beat this cycle.
- MemData  in  16  read data beat.
- Busy  out  1  fetch in progress.
- Overrun  out  1  sticky flag: a new request arrived before the previous row completed.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; BufferAddr=0, BufferData=0, BufferWrite=0, MemReq=0, MemAddr=0, Busy=0, Overrun=0; word counter=0; synchronizer flops=0.
- Request detection:
  - StartBuffer passes through a 2-flop synchronizer.
  - A request is the rising edge of the synchronized level (sync=1, previous=0).
  - Detection occurs 3 PixelClk2 edges after StartBuffer rises.
  - A level held high with no edge never retriggers.
- On request: latch GetRow into RowReg; WordCnt=0; go to REQ.
- States:
  - IDLE: MemReq=0, Busy=0. Request -> REQ.
  - REQ: MemReq=1, Busy=1, MemAddr = ROW_BASE + RowReg*WORDS_PER_ROW + WordCnt, truncated to ADDR_W. Hold until MemAck=1, then drop MemReq the following cycle and go to DATA.
  - DATA: each cycle MemDataValid=1, register BufferData=MemData, BufferAddr=WordCnt[8:0], BufferWrite=1 (1-cycle latency from beat to strobe); WordCnt+1. After BURST_LEN beats: WordCnt==WORDS_PER_ROW -> IDLE, else -> REQ.
- BufferWrite is 0 in every cycle without a registered beat. BufferAddr/BufferData hold their last values when BufferWrite=0.
- MemDataValid in IDLE or REQ is ignored; it produces no write.
- New request while Busy:
  - Set Overrun=1; it is sticky until Reset.
  - If in REQ before MemAck: relatch GetRow and restart at WordCnt=0 with no MemReq drop.
  - If in DATA: finish the current burst (the controller cannot abort), suppress its remaining BufferWrites, then REQ for the new row at WordCnt=0.
  - Request coincident with the final beat of a row: the final write still occurs, then the new row starts; Overrun=1.
- Arithmetic: RowReg*WORDS_PER_ROW is computed at ADDR_W width; overflow wraps modulo 2^ADDR_W.
- Reset mid-burst: immediate return to IDLE with outputs as at reset. The SDRAM controller shares Reset, so it also abandons the burst.

Optional Feature:
- ROW_FETCH_BYTESWAP_EN defined: BufferData = {MemData[7:0], MemData[15:8]}. This matches SDRAM images stored with the left pixel in the high byte.
- Undefined: BufferData = MemData unchanged. The row buffer's byte read port displays the low byte first.

Test Plan:
- Reset, then StartBuffer=1 with GetRow=5, controller acks after 2 cycles and returns beats 0x0100+n -> first MemAddr=0xA00. 64 bursts at MemAddr 0xA00, 0xA08, …, 0xBF8. 512 BufferWrite pulses at BufferAddr 0..511, data 0x0100..0x02FF. Busy falls after the last write; Overrun=0.
- StartBuffer held high for 3000 cycles after the fetch completes -> exactly one fetch (512 writes).
- MemDataValid pulsed while IDLE and during REQ -> no BufferWrite.
- Second StartBuffer edge (GetRow=7) during burst 10 of row 6 -> burst 10 drains with no writes. Next MemAddr=0xE00; BufferAddr restarts at 0; Overrun=1 until Reset.
- Reset asserted mid-DATA (beat 3) -> same cycle: BufferWrite=0, MemReq=0, Busy=0. After release, a new request fetches from WordCnt 0.
- Build with ROW_FETCH_BYTESWAP_EN and MemData=0x1234 -> BufferData=0x3412. Without the macro -> BufferData=0x1234.

Source files
------------

// File: rtl/row_fetch.sv
// row_fetch: burst-reads one display row of 8-bit palette indices from SDRAM into the
// video generator's 16-bit row buffer. Define ROW_FETCH_BYTESWAP_EN to swap each word's bytes.
module row_fetch #(
  parameter int WORDS_PER_ROW = 512,
  parameter int BURST_LEN     = 8,
  parameter int ROW_BASE      = 0,
  parameter int ADDR_W        = 22
) (
  input  logic              i_pixel_clk2,
  input  logic              i_reset,
  input  logic [10:0]       i_get_row,
  input  logic              i_start_buffer,
  output logic [8:0]        o_buffer_addr,
  output logic [15:0]       o_buffer_data,
  output logic              o_buffer_write,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic              i_mem_data_valid,
  input  logic [15:0]       i_mem_data,
  output logic              o_busy,
  output logic              o_overrun
);

  // state  | meaning
  // S_IDLE | no fetch in progress, waiting for a request edge
  // S_REQ  | burst request raised, waiting for the controller's ack
  // S_DATA | receiving the accepted burst; beats written unless draining

  localparam int CNT_W  = 10;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]  LP_WORDS     = CNT_W'(WORDS_PER_ROW);
  localparam logic [BEAT_W-1:0] LP_LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync_prev;
  logic [10:0]         r_row;
  logic [10:0]         w_row_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic                r_drain;
  logic                w_drain_nxt;
  logic                w_write;
  logic                w_req;
  logic                w_last_beat;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [8:0]          r_buf_addr;
  logic [15:0]         r_buf_data;
  logic                r_buf_write;
  logic                r_overrun;
  logic [15:0]         w_beat_data;

  assign w_req       = r_sync2 & ~r_sync_prev;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last_beat = i_mem_data_valid && (r_beat == LP_LAST_BEAT);

`ifdef ROW_FETCH_BYTESWAP_EN
  assign w_beat_data = {i_mem_data[7:0], i_mem_data[15:8]};
`else
  assign w_beat_data = i_mem_data;
`endif

  // Row offset wraps modulo 2^ADDR_W by construction of the sized operands.
  assign w_mem_addr_nxt = ADDR_W'(ROW_BASE)
                        + ADDR_W'(w_row_nxt) * ADDR_W'(WORDS_PER_ROW)
                        + ADDR_W'(w_cnt_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_beat_nxt  = r_beat;
    w_drain_nxt = r_drain;
    w_write     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_REQ;
          w_row_nxt   = i_get_row;
          w_cnt_nxt   = '0;
          w_drain_nxt = 1'b0;
        end
      end
      S_REQ: begin
        if (w_req) begin
          w_row_nxt = i_get_row;
          w_cnt_nxt = '0;
        end
        if (i_mem_ack) begin
          w_state_nxt = S_DATA;
          w_beat_nxt  = '0;
          // an ack coinciding with a new request commits the old burst; drain it
          w_drain_nxt = w_req;
        end
      end
      S_DATA: begin
        if (i_mem_data_valid) begin
          w_write    = ~r_drain;
          w_beat_nxt = r_beat + 1'b1;
          if (!r_drain) w_cnt_nxt = w_cnt_inc;
        end
        if (w_req) begin
          w_row_nxt   = i_get_row;
          w_cnt_nxt   = '0;
          w_drain_nxt = 1'b1;
        end
        if (w_last_beat) begin
          w_beat_nxt  = '0;
          w_drain_nxt = 1'b0;
          if (r_drain || w_req)
            w_state_nxt = S_REQ;
          else if (w_cnt_inc == LP_WORDS)
            w_state_nxt = S_IDLE;
          else
            w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pixel_clk2 or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_row       <= '0;
      r_cnt       <= '0;
      r_beat      <= '0;
      r_drain     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sync1     <= i_start_buffer;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_row       <= w_row_nxt;
      r_cnt       <= w_cnt_nxt;
      r_beat      <= w_beat_nxt;
      r_drain     <= w_drain_nxt;
    end
  end

  always_ff @(posedge i_pixel_clk2 or posedge i_reset) begin
    if (i_reset) begin
      r_mem_addr  <= '0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_buf_write <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_state_nxt == S_REQ) r_mem_addr <= w_mem_addr_nxt;
      r_buf_write <= w_write;
      if (w_write) begin
        r_buf_addr <= r_cnt[8:0];
        r_buf_data <= w_beat_data;
      end
      if (w_req && (r_state != S_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign o_mem_req      = (r_state == S_REQ);
  assign o_busy         = (r_state != S_IDLE);
  assign o_mem_addr     = r_mem_addr;
  assign o_buffer_addr  = r_buf_addr;
  assign o_buffer_data  = r_buf_data;
  assign o_buffer_write = r_buf_write;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_row_fetch.sv
// Bench for row_fetch: randomized SDRAM controller model, scoreboard of expected row writes
// and burst addresses derived from row number arithmetic.
module tb_row_fetch;
  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic [10:0]       get_row;
  logic              start;
  logic [8:0]        buf_addr;
  logic [15:0]       buf_data;
  logic              buf_wr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_dv;
  logic [15:0]       mem_data;
  logic              busy;
  logic              overrun;

  row_fetch #(.WORDS_PER_ROW(512), .BURST_LEN(8), .ROW_BASE(0), .ADDR_W(ADDR_W)) dut (
    .i_pixel_clk2     (clk),
    .i_reset          (rst),
    .i_get_row        (get_row),
    .i_start_buffer   (start),
    .o_buffer_addr    (buf_addr),
    .o_buffer_data    (buf_data),
    .o_buffer_write   (buf_wr),
    .o_mem_req        (mem_req),
    .o_mem_addr       (mem_addr),
    .i_mem_ack        (mem_ack),
    .i_mem_data_valid (mem_dv),
    .i_mem_data       (mem_data),
    .o_busy           (busy),
    .o_overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SDRAM content: word at address a is (a - 0x900), so row 5 reads 0x0100, 0x0101, ...
  function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] d;
    d = a - 22'h900;
    return d[15:0];
  endfunction

  function automatic logic [15:0] lane(input logic [15:0] w);
`ifdef ROW_FETCH_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  logic [24:0]       wr_q[$];
  logic [24:0]       exp_q[$];
  logic [ADDR_W-1:0] acc_q[$];
  logic [ADDR_W-1:0] exp_acc[$];
  int                burst_cnt  = 0;
  int                stall_at   = -1;
  int                cur_beat   = -1;
  bit                stall_hit  = 1'b0;
  bit                spur_en    = 1'b0;
  bit                idle_noise = 1'b0;

  always @(negedge clk) if (buf_wr === 1'b1) wr_q.push_back({buf_addr, buf_data});

  task automatic serve_burst();
    int d;
    logic [ADDR_W-1:0] base;
    d = $urandom_range(0, 3);
    repeat (d) begin
      if (spur_en) begin
        mem_dv   = 1'($urandom_range(0, 1));
        mem_data = 16'hBEEF;
      end
      @(posedge clk); #1;
      mem_dv = 1'b0;
      if (rst) return;
    end
    base = mem_addr;
    acc_q.push_back(base);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    if (rst) return;
    if (burst_cnt == stall_at) begin
      stall_hit = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      if (rst) return;
    end
    burst_cnt++;
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        if (rst) return;
      end
      cur_beat = b;
      mem_dv   = 1'b1;
      mem_data = mem_word(base + ADDR_W'(b));
      @(posedge clk); #1;
      mem_dv   = 1'b0;
      cur_beat = -1;
      if (rst) return;
    end
  endtask

  initial begin
    mem_ack = 1'b0; mem_dv = 1'b0; mem_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_dv  = 1'b0;
      mem_ack = 1'b0;
      cur_beat = -1;
      if (rst || !mem_req) begin
        if (idle_noise && !rst) begin
          mem_dv   = 1'($urandom_range(0, 1));
          mem_data = 16'hDEAD;
        end
        continue;
      end
      serve_burst();
    end
  end

  task automatic clear_all();
    wr_q.delete(); exp_q.delete(); acc_q.delete(); exp_acc.delete();
    burst_cnt = 0;
  endtask

  task automatic expect_row(input int row, input int n_wr, input int n_burst);
    logic [ADDR_W-1:0] base;
    base = ADDR_W'(row * 512);
    for (int k = 0; k < n_wr; k++)
      exp_q.push_back({9'(k), lane(mem_word(base + ADDR_W'(k)))});
    for (int b = 0; b < n_burst; b++)
      exp_acc.push_back(base + ADDR_W'(b * 8));
  endtask

  task automatic cmp_run(input string tag);
    int bad;
    bad = 0;
    check({tag, ".wr_cnt"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) bad++;
    check({tag, ".wr_bad"}, bad, 0);
    bad = 0;
    check({tag, ".burst_cnt"}, acc_q.size(), exp_acc.size());
    for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
      if (acc_q[i] !== exp_acc[i]) bad++;
    check({tag, ".burst_bad"}, bad, 0);
  endtask

  task automatic wait_busy(input logic lvl, input int max, input string tag);
    int t;
    t = 0;
    while (busy !== lvl && t < max) begin @(negedge clk); t++; end
    check(tag, busy, lvl);
  endtask

  task automatic run_fetch(input logic [10:0] row);
    clear_all();
    get_row = row;
    start   = 1'b1;
    wait_busy(1'b1, 10, "busy_rise");
    start = 1'b0;
    wait_busy(1'b0, 20000, "busy_fall");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [10:0] row;
    logic [15:0] swap_exp;
    rst = 1'b1; start = 1'b0; get_row = '0;
    repeat (3) @(negedge clk);
    check("rst.buf_addr", buf_addr, 0);
    check("rst.buf_data", buf_data, 0);
    check("rst.buf_wr",   buf_wr,   0);
    check("rst.mem_req",  mem_req,  0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.busy",     busy,     0);
    check("rst.overrun",  overrun,  0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Row 5 with the request level left high afterwards
    clear_all();
    spur_en = 1'b1;
    get_row = 11'd5;
    start   = 1'b1;
    @(negedge clk); check("lat.c1", busy, 0);
    @(negedge clk); check("lat.c2", busy, 0);
    @(negedge clk); check("lat.c3", busy, 1);
    check("row5.first_addr", mem_addr, 22'hA00);
    check("row5.mem_req", mem_req, 1);
    wait_busy(1'b0, 20000, "row5.busy_fall");
    repeat (2) @(negedge clk);
    expect_row(5, 512, 64);
    cmp_run("row5");
    if (wr_q.size() > 0) check("row5.first_data", wr_q[0][15:0], lane(16'h0100));
    check("row5.overrun", overrun, 0);
    idle_noise = 1'b1;
    repeat (3000) @(negedge clk);
    idle_noise = 1'b0;
    check("hold.wr_cnt", wr_q.size(), 512);
    check("hold.bursts", acc_q.size(), 64);
    check("hold.busy", busy, 0);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // Row 13 contains SDRAM word 0x1234 at offset 308, then random rows
    run_fetch(11'd13);
    expect_row(13, 512, 64);
    cmp_run("row13");
`ifdef ROW_FETCH_BYTESWAP_EN
    swap_exp = 16'h3412;
`else
    swap_exp = 16'h1234;
`endif
    if (wr_q.size() > 308) check("lane_order", wr_q[308][15:0], swap_exp);
    for (int i = 0; i < 2; i++) begin
      row = 11'($urandom_range(0, 2047));
      run_fetch(row);
      expect_row(int'(row), 512, 64);
      cmp_run("rand_row");
    end
    check("rand.overrun", overrun, 0);

    // New request (row 7) arrives after burst 10 of row 6 is accepted, before its beats
    clear_all();
    stall_hit = 1'b0;
    stall_at  = 10;
    get_row   = 11'd6;
    start     = 1'b1;
    wait_busy(1'b1, 10, "ovr.busy_rise");
    start = 1'b0;
    t = 0;
    while (!stall_hit && t < 3000) begin @(negedge clk); t++; end
    check("ovr.stall_seen", stall_hit, 1);
    get_row = 11'd7;
    start   = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    check("ovr.flag", overrun, 1);
    check("ovr.busy", busy, 1);
    wait_busy(1'b0, 20000, "ovr.busy_fall");
    repeat (2) @(negedge clk);
    stall_at = -1;
    expect_row(6, 80, 11);
    expect_row(7, 512, 64);
    cmp_run("ovr");
    if (acc_q.size() > 11) check("ovr.next_addr", acc_q[11], 22'hE00);
    run_fetch(11'd3);
    expect_row(3, 512, 64);
    cmp_run("row3");
    check("ovr.sticky", overrun, 1);

    // Reset while beat 3 of a burst is on the bus
    clear_all();
    get_row = 11'd9;
    start   = 1'b1;
    wait_busy(1'b1, 10, "rst.busy_rise");
    start = 1'b0;
    t = 0;
    while (cur_beat != 3 && t < 500) begin @(negedge clk); t++; end
    check("rst.beat_seen", cur_beat, 3);
    rst = 1'b1;
    #1;
    check("rstmid.buf_wr",  buf_wr,  0);
    check("rstmid.mem_req", mem_req, 0);
    check("rstmid.busy",    busy,    0);
    check("rstmid.overrun", overrun, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_fetch(11'd2);
    expect_row(2, 512, 64);
    cmp_run("after_rst");
    check("after_rst.overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
